// File: rtl/alu_pkg.sv
// Shared opcode, FSM encoding and opcode helpers for the ALU slice and its sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_SLT_FIX = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Ops that invert B and inject a carry-in of 1
  function automatic logic is_sub(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  // Ops whose signed overflow is reported
  function automatic logic has_ovf(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_i.sv
// 1-bit ALU slice: logic ops, full add/subtract bit and SLT pass-through of 'less'.
module alu_i
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [3:0] alu_control,
  output logic       result,
  output logic       cout
);

  logic b_eff;
  logic sum;

  // Adder bit with conditional B inversion, then opcode mux
  always_comb begin
    b_eff  = b ^ is_sub(alu_control);
    sum    = a ^ b_eff ^ cin;
    cout   = (a & b_eff) | (a & cin) | (b_eff & cin);
    result = 1'b0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_SUB: result = sum;
      ALU_SLT: result = less;
      ALU_NOR: result = ~(a | b);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU: drives one alu_i slice LSB-first, one bit per clock, with registered results.
module alu_serial_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [3:0]         op_q, op_d;
  logic               ovf_q, ovf_d;
  logic               set_q, set_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;

  logic               sl_res;
  logic               sl_cout;

  alu_i u_slice (
    .a           (a_sh_q[0]),
    .b           (b_sh_q[0]),
    .cin         (carry_q),
    .less        (1'b0),
    .alu_control (op_q),
    .result      (sl_res),
    .cout        (sl_cout)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    op_d       = op_q;
    ovf_d      = ovf_q;
    set_d      = set_q;
    done_d     = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = alu_control;
          idx_d   = '0;
          carry_d = is_sub(alu_control);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_sh_d = {sl_res, res_sh_q[WIDTH-1:1]};
        carry_d  = sl_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        idx_d    = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_LAST) begin
          // Overflow from MSB carries; set is the overflow-corrected sign of a-b
          ovf_d   = carry_q ^ sl_cout;
          set_d   = a_sh_q[0] ^ ~b_sh_q[0] ^ carry_q ^ (carry_q ^ sl_cout);
          idx_d   = '0;
          state_d = (op_q == ALU_SLT) ? S_SLT_FIX : S_DONE;
        end
      end
      S_SLT_FIX: begin
        res_sh_d = {{(WIDTH-1){1'b0}}, set_q};
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result and flags are loaded on entry to DONE so they are valid with the done pulse
    if (state_d == S_DONE) begin
      done_d     = 1'b1;
      result_d   = res_sh_d;
      zero_d     = (res_sh_d == '0);
      overflow_d = has_ovf(op_q) ? ovf_d : 1'b0;
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN) || (state_d == S_SLT_FIX);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      op_q       <= '0;
      ovf_q      <= 1'b0;
      set_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      op_q       <= op_d;
      ovf_q      <= ovf_d;
      set_q      <= set_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule
